// File: rtl/instr_decode.sv
// Single-stage instruction decoder with a register scoreboard for RAW/WAW hazard
// detection, a halt state and a saturating stall counter.
module instr_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  op,
  output logic [3:0]  Rd,
  output logic [3:0]  Rs1,
  output logic [3:0]  Rs2,
  output logic [31:0] imm,
  output logic        rd_allow,
  output logic        wr_allow,
  input  logic        wb_valid,
  input  logic [3:0]  wb_rd,
  input  logic        flush,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [3:0]  op_q, op_d;
  logic [3:0]  rd_q, rd_d;
  logic [3:0]  rs1_q, rs1_d;
  logic [3:0]  rs2_q, rs2_d;
  logic [31:0] imm_q, imm_d;
  logic        rd_allow_q, rd_allow_d;
  logic        wr_allow_q, wr_allow_d;
  logic [15:0] busy_q, busy_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic [3:0] in_op, in_rd, in_rs1, in_rs2;
  logic       use_rs1, use_rs2, writes;
  logic       pend_wr, hz_rs1, hz_rs2, hz_rd, hazard;
  logic       accept, handoff;

  assign in_op  = in_instr[31:28];
  assign in_rd  = in_instr[27:24];
  assign in_rs1 = in_instr[23:20];
  assign in_rs2 = in_instr[19:16];

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    writes  = 1'b0;
    if (in_op inside {[4'h1:4'h7]}) begin
      use_rs1 = 1'b1;
      use_rs2 = 1'b1;
      writes  = 1'b1;
    end else if (in_op inside {[4'h8:4'hC]}) begin
      use_rs1 = 1'b1;
      writes  = 1'b1;
    end else if (in_op == 4'hD || in_op == 4'hE) begin
      use_rs1 = 1'b1;
      use_rs2 = 1'b1;
    end
  end

  // The instruction sitting in the output register has not yet set its busy bit.
  assign pend_wr = out_valid_q && wr_allow_q;
  assign hz_rs1  = use_rs1 && (busy_q[in_rs1] || (pend_wr && in_rs1 == rd_q));
  assign hz_rs2  = use_rs2 && (busy_q[in_rs2] || (pend_wr && in_rs2 == rd_q));
  assign hz_rd   = writes  && (busy_q[in_rd]  || (pend_wr && in_rd  == rd_q));
  assign hazard  = hz_rs1 || hz_rs2 || hz_rd;

  assign in_ready = (state_q == StRun) && !flush && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    op_d        = op_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    rd_allow_d  = rd_allow_q;
    wr_allow_d  = wr_allow_q;
    busy_d      = busy_q;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      op_d        = in_op;
      rd_d        = in_rd;
      rs1_d       = in_rs1;
      rs2_d       = in_rs2;
      imm_d       = {{16{in_instr[15]}}, in_instr[15:0]};
      rd_allow_d  = use_rs1 || use_rs2;
      wr_allow_d  = writes;
    end else if (handoff) begin
      out_valid_d = 1'b0;
    end

    // Set is applied after clear so it wins on a collision.
    if (wb_valid) busy_d[wb_rd] = 1'b0;
    if (handoff && wr_allow_q && !flush) busy_d[rd_q] = 1'b1;

    if (accept && in_op == 4'hF) state_d = StHalt;

    if (in_valid && hazard && state_q == StRun && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      out_valid_q <= 1'b0;
      op_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      rd_allow_q  <= 1'b0;
      wr_allow_q  <= 1'b0;
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      imm_q       <= imm_d;
      rd_allow_q  <= rd_allow_d;
      wr_allow_q  <= wr_allow_d;
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign op        = op_q;
  assign Rd        = rd_q;
  assign Rs1       = rs1_q;
  assign Rs2       = rs2_q;
  assign imm       = imm_q;
  assign rd_allow  = rd_allow_q;
  assign wr_allow  = wr_allow_q;
  assign halted    = (state_q == StHalt);
  assign stall_cnt = stall_cnt_q;

endmodule
